// File: rtl/pipe_control.sv
// ID-stage pipeline control: opcode decode, ID/EX control register, load-use stall FSM.
// Define PIPE_CONTROL_MULDIV_EN to enable multi-cycle multiply/divide occupancy (MDBUSY).
//
// state  | meaning
// IDLE   | normal issue; checks load-use hazard each cycle
// LSTALL | extra load-use bubbles after the first, counted down in cnt
// MDBUSY | multiply/divide occupying EX, counted down in cnt
module pipe_control #(
    parameter int REG_ADDR_W   = 5,
    parameter int LOAD_BUBBLES = 1,
    parameter int MULDIV_LAT   = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    input  logic [6:0]            op_i,
    input  logic [6:0]            funct7_i,
    input  logic [REG_ADDR_W-1:0] rs1_i,
    input  logic [REG_ADDR_W-1:0] rs2_i,
    input  logic [REG_ADDR_W-1:0] rd_i,
    input  logic                  flush_i,
    output logic                  stall_o,
    output logic [1:0]            ex_alu_op_o,
    output logic                  ex_alu_src_o,
    output logic                  ex_reg_write_o,
    output logic                  ex_mem_read_o,
    output logic                  ex_mem_write_o,
    output logic                  ex_mem_to_reg_o,
    output logic                  ex_branch_o,
    output logic [REG_ADDR_W-1:0] ex_rd_o,
    output logic                  ex_valid_o
);

`ifdef PIPE_CONTROL_MULDIV_EN
    localparam logic MD_EN = 1'b1;
`else
    localparam logic MD_EN = 1'b0;
`endif

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LSTALL = 2'd1,
        MDBUSY = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic        w_stall;
    logic        w_issue;
    logic        w_hazard;
    logic        w_is_muldiv;

    // Decoded bundle: {alu_op[1:0], alu_src, reg_write, mem_read, mem_write, mem_to_reg, branch}
    logic [7:0]  w_dec;

    always_comb begin
        w_dec = 8'b0000_0000;
        case (op_i)
            OP_RTYPE:  w_dec = 8'b00_0_1_0_0_0_0;
            OP_ITYPE:  w_dec = 8'b01_1_1_0_0_0_0;
            OP_LOAD:   w_dec = 8'b01_1_1_1_0_1_0;
            OP_STORE:  w_dec = 8'b10_1_0_0_1_0_0;
            OP_BRANCH: w_dec = 8'b11_0_0_0_0_0_1;
            default:   w_dec = 8'b0000_0000;
        endcase
    end

    // x0 is never a real producer, so a load to rd=0 cannot create a hazard
    assign w_hazard = valid_i && ex_valid_o && ex_mem_read_o && (ex_rd_o != '0)
                      && ((ex_rd_o == rs1_i) || (ex_rd_o == rs2_i));

    assign w_is_muldiv = (op_i == OP_RTYPE) && (funct7_i == 7'b0000001);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stall     = 1'b0;
        w_issue     = 1'b0;
        if (flush_i) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = 4'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_hazard) begin
                        w_stall = 1'b1;
                        if (LOAD_BUBBLES > 1) begin
                            w_state_nxt = LSTALL;
                            w_cnt_nxt   = 4'(LOAD_BUBBLES - 1);
                        end
                    end else if (valid_i) begin
                        w_issue = 1'b1;
                        if (MD_EN && w_is_muldiv) begin
                            w_state_nxt = MDBUSY;
                            w_cnt_nxt   = 4'(MULDIV_LAT - 1);
                        end
                    end
                end
                LSTALL, MDBUSY: begin
                    w_stall   = 1'b1;
                    w_cnt_nxt = r_cnt - 4'd1;
                    if (r_cnt <= 4'd1) begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = 4'd0;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ex_alu_op_o     <= 2'b00;
            ex_alu_src_o    <= 1'b0;
            ex_reg_write_o  <= 1'b0;
            ex_mem_read_o   <= 1'b0;
            ex_mem_write_o  <= 1'b0;
            ex_mem_to_reg_o <= 1'b0;
            ex_branch_o     <= 1'b0;
            ex_rd_o         <= '0;
            ex_valid_o      <= 1'b0;
        end else if (w_issue) begin
            ex_alu_op_o     <= w_dec[7:6];
            ex_alu_src_o    <= w_dec[5];
            ex_reg_write_o  <= w_dec[4];
            ex_mem_read_o   <= w_dec[3];
            ex_mem_write_o  <= w_dec[2];
            ex_mem_to_reg_o <= w_dec[1];
            ex_branch_o     <= w_dec[0];
            ex_rd_o         <= rd_i;
            ex_valid_o      <= 1'b1;
        end else begin
            ex_alu_op_o     <= 2'b00;
            ex_alu_src_o    <= 1'b0;
            ex_reg_write_o  <= 1'b0;
            ex_mem_read_o   <= 1'b0;
            ex_mem_write_o  <= 1'b0;
            ex_mem_to_reg_o <= 1'b0;
            ex_branch_o     <= 1'b0;
            ex_rd_o         <= '0;
            ex_valid_o      <= 1'b0;
        end
    end

    assign stall_o = w_stall && rst_i;

endmodule

// File: tb/tb_pipe_control.sv
// Directed self-checking bench for pipe_control (LOAD_BUBBLES=2, MULDIV_LAT=4).
// Muldiv expectations follow whether PIPE_CONTROL_MULDIV_EN is defined for the build.
module tb_pipe_control;

    localparam int AW = 5;

    localparam logic [6:0] R  = 7'b0110011;
    localparam logic [6:0] I  = 7'b0010011;
    localparam logic [6:0] LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011;
    localparam logic [6:0] BR = 7'b1100011;

    // Expected control bytes {alu_op, src, rw, mr, mw, m2r, br}
    localparam logic [7:0] C_R  = 8'b00010000;
    localparam logic [7:0] C_I  = 8'b01110000;
    localparam logic [7:0] C_LD = 8'b01111010;
    localparam logic [7:0] C_ST = 8'b10100100;
    localparam logic [7:0] C_BR = 8'b11000001;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          valid_i;
    logic [6:0]    op_i;
    logic [6:0]    funct7_i;
    logic [AW-1:0] rs1_i, rs2_i, rd_i;
    logic          flush_i;
    logic          stall_o;
    logic [1:0]    ex_alu_op_o;
    logic          ex_alu_src_o, ex_reg_write_o, ex_mem_read_o;
    logic          ex_mem_write_o, ex_mem_to_reg_o, ex_branch_o;
    logic [AW-1:0] ex_rd_o;
    logic          ex_valid_o;

    int n_total = 0;
    int n_pass  = 0;

    pipe_control #(
        .REG_ADDR_W  (AW),
        .LOAD_BUBBLES(2),
        .MULDIV_LAT  (4)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .valid_i        (valid_i),
        .op_i           (op_i),
        .funct7_i       (funct7_i),
        .rs1_i          (rs1_i),
        .rs2_i          (rs2_i),
        .rd_i           (rd_i),
        .flush_i        (flush_i),
        .stall_o        (stall_o),
        .ex_alu_op_o    (ex_alu_op_o),
        .ex_alu_src_o   (ex_alu_src_o),
        .ex_reg_write_o (ex_reg_write_o),
        .ex_mem_read_o  (ex_mem_read_o),
        .ex_mem_write_o (ex_mem_write_o),
        .ex_mem_to_reg_o(ex_mem_to_reg_o),
        .ex_branch_o    (ex_branch_o),
        .ex_rd_o        (ex_rd_o),
        .ex_valid_o     (ex_valid_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    function automatic logic [13:0] ex_bus();
        return {ex_alu_op_o, ex_alu_src_o, ex_reg_write_o, ex_mem_read_o,
                ex_mem_write_o, ex_mem_to_reg_o, ex_branch_o, ex_rd_o, ex_valid_o};
    endfunction

    function automatic logic [13:0] bund(input logic [7:0] c, input logic [AW-1:0] rd,
                                         input logic v);
        return {c, rd, v};
    endfunction

    task automatic chk(input string tag, input logic [13:0] obs, input logic [13:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic [6:0] op, input logic [6:0] f7,
                         input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                         input logic [AW-1:0] d, input logic fl);
        valid_i  = v;
        op_i     = op;
        funct7_i = f7;
        rs1_i    = s1;
        rs2_i    = s2;
        rd_i     = d;
        flush_i  = fl;
    endtask

    // Inputs are driven 1 time unit after a rising edge; stall is sampled 1 unit later,
    // the ID/EX register 1 unit after the following edge.
    task automatic step(input string tag, input logic exp_stall, input logic [13:0] exp_ex);
        #1;
        chk({tag, "/stall"}, {13'd0, stall_o}, {13'd0, exp_stall});
        @(posedge clk_i);
        #1;
        chk({tag, "/ex"}, ex_bus(), exp_ex);
    endtask

    initial begin
        rst_i = 1'b0;
        drive(1'b0, 7'd0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        @(posedge clk_i);
        #1;

        // Reset held while inputs toggle, including a would-be issue and flush
        drive(1'b1, LD, 7'd0, 5'd1, 5'd2, 5'd5, 1'b0);
        step("rst_ld", 1'b0, 14'd0);
        drive(1'b1, R, 7'd1, 5'd5, 5'd5, 5'd7, 1'b1);
        step("rst_r", 1'b0, 14'd0);
        drive(1'b1, BR, 7'd0, 5'd3, 5'd4, 5'd9, 1'b0);
        #2;
        rst_i = 1'b1;
        drive(1'b0, BR, 7'd0, 5'd3, 5'd4, 5'd9, 1'b0);
        step("post_rst_idle", 1'b0, 14'd0);

        // Decode of every opcode class, one-cycle latency
        drive(1'b1, LD, 7'd0, 5'd1, 5'd2, 5'd5, 1'b0);
        step("dec_load", 1'b0, bund(C_LD, 5'd5, 1'b1));
        drive(1'b1, I, 7'd0, 5'd1, 5'd2, 5'd7, 1'b0);
        step("dec_itype", 1'b0, bund(C_I, 5'd7, 1'b1));
        drive(1'b1, ST, 7'd0, 5'd7, 5'd8, 5'd4, 1'b0);
        step("dec_store", 1'b0, bund(C_ST, 5'd4, 1'b1));
        drive(1'b1, BR, 7'd0, 5'd4, 5'd6, 5'd0, 1'b0);
        step("dec_branch", 1'b0, bund(C_BR, 5'd0, 1'b1));
        drive(1'b1, 7'b1111111, 7'd0, 5'd1, 5'd2, 5'd9, 1'b0);
        step("dec_other", 1'b0, bund(8'd0, 5'd9, 1'b1));

        // Load-use on rs1: two stall cycles, two bubbles, then issue
        drive(1'b1, LD, 7'd0, 5'd1, 5'd2, 5'd3, 1'b0);
        step("lu_load", 1'b0, bund(C_LD, 5'd3, 1'b1));
        drive(1'b1, R, 7'd0, 5'd3, 5'd0, 5'd6, 1'b0);
        step("lu_bub1", 1'b1, 14'd0);
        step("lu_bub2", 1'b1, 14'd0);
        step("lu_issue", 1'b0, bund(C_R, 5'd6, 1'b1));

        // Load-use on rs2, flushed during the LSTALL cycle
        drive(1'b1, LD, 7'd0, 5'd1, 5'd2, 5'd3, 1'b0);
        step("fl_load", 1'b0, bund(C_LD, 5'd3, 1'b1));
        drive(1'b1, R, 7'd0, 5'd0, 5'd3, 5'd6, 1'b0);
        step("fl_haz", 1'b1, 14'd0);
        drive(1'b1, R, 7'd0, 5'd0, 5'd3, 5'd6, 1'b1);
        step("fl_flush", 1'b0, 14'd0);
        drive(1'b1, R, 7'd0, 5'd0, 5'd3, 5'd6, 1'b0);
        step("fl_idle_issue", 1'b0, bund(C_R, 5'd6, 1'b1));

        // Flush in IDLE squashes a valid instruction
        drive(1'b1, I, 7'd0, 5'd1, 5'd1, 5'd12, 1'b1);
        step("fl_squash", 1'b0, 14'd0);

        // Load to x0 followed by x0 readers: no hazard
        drive(1'b1, LD, 7'd0, 5'd1, 5'd2, 5'd0, 1'b0);
        step("x0_load", 1'b0, bund(C_LD, 5'd0, 1'b1));
        drive(1'b1, R, 7'd0, 5'd0, 5'd0, 5'd2, 1'b0);
        step("x0_read", 1'b0, bund(C_R, 5'd2, 1'b1));

        // Matching rs but ID not valid: no stall, bubble
        drive(1'b1, LD, 7'd0, 5'd1, 5'd2, 5'd3, 1'b0);
        step("nv_load", 1'b0, bund(C_LD, 5'd3, 1'b1));
        drive(1'b0, R, 7'd0, 5'd3, 5'd3, 5'd6, 1'b0);
        step("nv_idle", 1'b0, 14'd0);

        // Asynchronous reset clears a live ID/EX register without a clock edge
        drive(1'b1, I, 7'd0, 5'd1, 5'd2, 5'd10, 1'b0);
        step("ar_issue", 1'b0, bund(C_I, 5'd10, 1'b1));
        #1;
        rst_i = 1'b0;
        #1;
        chk("ar_async_ex", ex_bus(), 14'd0);
        #1;
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;

        // Reset during LSTALL abandons the stall
        drive(1'b1, LD, 7'd0, 5'd1, 5'd2, 5'd3, 1'b0);
        step("rs_load", 1'b0, bund(C_LD, 5'd3, 1'b1));
        drive(1'b1, R, 7'd0, 5'd3, 5'd0, 5'd6, 1'b0);
        step("rs_haz", 1'b1, 14'd0);
        rst_i = 1'b0;
        step("rs_in_rst", 1'b0, 14'd0);
        rst_i = 1'b1;
        step("rs_release", 1'b0, bund(C_R, 5'd6, 1'b1));

        // Multiply/divide occupancy
        drive(1'b1, R, 7'b0000001, 5'd1, 5'd2, 5'd8, 1'b0);
        step("md_issue", 1'b0, bund(C_R, 5'd8, 1'b1));
        drive(1'b1, I, 7'd0, 5'd1, 5'd2, 5'd9, 1'b0);
`ifdef PIPE_CONTROL_MULDIV_EN
        step("md_busy1", 1'b1, 14'd0);
        step("md_busy2", 1'b1, 14'd0);
        step("md_busy3", 1'b1, 14'd0);
        step("md_done", 1'b0, bund(C_I, 5'd9, 1'b1));
        drive(1'b1, R, 7'b0000001, 5'd1, 5'd2, 5'd8, 1'b0);
        step("md2_issue", 1'b0, bund(C_R, 5'd8, 1'b1));
        drive(1'b1, I, 7'd0, 5'd1, 5'd2, 5'd9, 1'b0);
        step("md2_busy1", 1'b1, 14'd0);
        drive(1'b1, I, 7'd0, 5'd1, 5'd2, 5'd9, 1'b1);
        step("md2_flush", 1'b0, 14'd0);
        drive(1'b1, I, 7'd0, 5'd1, 5'd2, 5'd9, 1'b0);
        step("md2_after", 1'b0, bund(C_I, 5'd9, 1'b1));
`else
        step("md_off_next", 1'b0, bund(C_I, 5'd9, 1'b1));
        drive(1'b1, R, 7'b0000001, 5'd9, 5'd9, 5'd11, 1'b0);
        step("md_off_r2", 1'b0, bund(C_R, 5'd11, 1'b1));
        drive(1'b0, 7'd0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        step("md_off_idle", 1'b0, 14'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipe_control.md
PIPE_CONTROL -- requirements
Module: pipe_control

Interface
REQ-001 The block SHALL take parameter REG_ADDR_W, default 5: register-address width.
REQ-002 The block SHALL take parameter LOAD_BUBBLES, default 1: load-use stall length in cycles, legal range 1..3.
REQ-003 The block SHALL take parameter MULDIV_LAT, default 4: multiply/divide occupancy in cycles, legal range 2..15.
REQ-004 The block SHALL have the port clk_i, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-005 The block SHALL have the port rst_i, input, 1 bit: the reset, which is asynchronous and active-low.
REQ-006 The block SHALL have the port valid_i, input, 1 bit: the ID stage holds a real instruction.
REQ-007 The block SHALL have the ports op_i (7 bits) and funct7_i (7 bits), inputs: the ID instruction fields.
REQ-008 The block SHALL have the ports rs1_i, rs2_i and rd_i, inputs, REG_ADDR_W bits each: the ID register addresses.
REQ-009 The block SHALL have the port flush_i, input, 1 bit: a branch is taken, so the ID instruction is squashed.
REQ-010 The block SHALL have the port stall_o, output, 1 bit: hold PC and IF/ID this cycle (combinational).
REQ-011 The block SHALL have the port ex_alu_op_o, output, 2 bits: registered ALUOp for the EX stage.
REQ-012 The block SHALL have the ports ex_alu_src_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_mem_to_reg_o and ex_branch_o, outputs, 1 bit each: registered EX control.
REQ-013 The block SHALL have the ports ex_rd_o (REG_ADDR_W bits) and ex_valid_o (1 bit), outputs: registered EX destination register and EX valid.

Function
REQ-014 Decode SHALL map opcodes to ALUOp/ALUSrc/RegWrite/MemRead/MemWrite/MemToReg/Branch as follows:
- R-type 0110011 -> 00/0/1/0/0/0/0
- I-type 0010011 -> 01/1/1/0/0/0/0
- LOAD 0000011 -> 01/1/1/1/0/1/0
- STORE 0100011 -> 10/1/0/0/1/0/0
- BRANCH 1100011 -> 11/0/0/0/0/0/1
- any other opcode -> all zero
REQ-015 The ID/EX register SHALL load on every clock edge: either the decoded bundle plus rd_i with ex_valid_o=1 (issue), or a bubble (all ex_* outputs zero).
REQ-016 Issue-to-ex_* latency SHALL be exactly one cycle.
REQ-017 A hazard SHALL be flagged when all of the following hold: valid_i=1, ex_valid_o=1, ex_mem_read_o=1, ex_rd_o!=0, and ex_rd_o equals rs1_i or rs2_i.
REQ-018 The FSM SHALL have the states IDLE, LSTALL and MDBUSY, plus a 4-bit down-counter cnt.
REQ-019 In IDLE with a hazard, the block SHALL assert stall_o, load a bubble, and go to LSTALL with cnt=LOAD_BUBBLES-1 if LOAD_BUBBLES>1; otherwise it SHALL remain in IDLE.
REQ-020 In IDLE with no hazard and valid_i=1, the block SHALL issue; with valid_i=0 it SHALL load a bubble; stall_o SHALL be 0 in both cases.
REQ-021 In LSTALL, the block SHALL assert stall_o, load a bubble and decrement cnt, returning to IDLE when cnt was 1.
REQ-022 flush_i=1 SHALL take priority over every other condition: load a bubble, force IDLE, clear cnt, and hold stall_o=0 that cycle.
REQ-023 stall_o SHALL never assert while valid_i=0 and the FSM is in IDLE.

Reset
REQ-024 When rst_i=0, the block SHALL immediately and asynchronously set all ex_* outputs to 0, the FSM to IDLE and cnt to 0, regardless of clk_i.
REQ-025 While rst_i=0, stall_o SHALL be 0.
REQ-026 Reset asserted mid-stall SHALL abandon the stall, and the first edge after release SHALL behave as IDLE.

Configuration
REQ-027 Macro PIPE_CONTROL_MULDIV_EN SHALL gate the multiply/divide occupancy feature.
REQ-028 When PIPE_CONTROL_MULDIV_EN is defined, an R-type instruction with funct7_i=0000001 that issues from IDLE SHALL move the FSM to MDBUSY with cnt=MULDIV_LAT-1.
REQ-029 In MDBUSY, the block SHALL assert stall_o, load bubbles and decrement cnt, returning to IDLE when cnt was 1; flush_i SHALL abort MDBUSY per REQ-022.
REQ-030 When PIPE_CONTROL_MULDIV_EN is not defined, funct7_i SHALL be ignored, the MDBUSY state SHALL be unreachable, and such R-type instructions SHALL issue as plain R-type.

Verification
REQ-031 Scenario reset: hold rst_i=0 while other inputs toggle -> every ex_* output and stall_o stay 0; after release with valid_i=0 the outputs stay 0.
REQ-032 Scenario decode: issue op_i=0000011, rd_i=5 -> next cycle ex_alu_op_o=01, ex_alu_src_o=1, ex_mem_read_o=1, ex_mem_to_reg_o=1, ex_rd_o=5, ex_valid_o=1.
REQ-033 Scenario load-use: issue LOAD rd=3, then R-type rs1=3 with LOAD_BUBBLES=2 -> stall_o=1 for exactly 2 cycles, 2 bubbles, then the R-type issues.
REQ-034 Scenario no false hazard: LOAD with rd=0 followed by an instruction reading x0 -> stall_o stays 0.
REQ-035 Scenario flush: flush_i=1 during the first LSTALL cycle -> stall_o=0, bubble loaded, FSM in IDLE on the next cycle.
REQ-036 Scenario muldiv: with PIPE_CONTROL_MULDIV_EN defined and MULDIV_LAT=4, issue funct7=0000001 R-type -> stall_o=1 for 3 cycles; without the macro -> stall_o=0 throughout.
